keccak_reg_ctrl: RTL

Register-mapped control and buffering stage between the X-HEEP external peripheral register bus and the Keccak-f[1600] permutation core. It collects the 1600-bit input state from 32-bit software writes and launches the core with a start/done handshake. It captures the permuted state into readable output registers and raises a level interrupt into the external interrupt vector on completion.

---
 rtl/keccak_reg_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/keccak_reg_ctrl.sv
// Register front-end for a Keccak-f[1600] core: 32-bit bus writes fill the state, START launches the core, and the permuted state is captured for readback.
// Optional CTRL.CHAIN (macro KECCAK_CHAIN_EN) launches on DIN ^ DOUT; the bus is always ready, with rdata/error combinational.
package keccak_reg_pkg;
   typedef struct packed {
      logic        valid;
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } reg_req_t;

   typedef struct packed {
      logic        ready;
      logic        error;
      logic [31:0] rdata;
   } reg_rsp_t;
endpackage

module keccak_reg_ctrl
   import keccak_reg_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  reg_req_t        reg_req_i,
   output reg_rsp_t        reg_rsp_o,
   output logic [1599:0]   core_state_o,
   output logic            core_start_o,
   input  logic [1599:0]   core_state_i,
   input  logic            core_done_i,
   output logic            keccak_int_o
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LAUNCH = 2'd1, S_WAIT = 2'd2} state_e;

   state_e             state_q, state_d;
   logic [1599:0]      din_q, din_d, dout_q, dout_d, core_q, core_d;
   logic               irq_en_q, irq_en_d, done_q, done_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef KECCAK_CHAIN_EN
   logic               chain_q, chain_d;
`endif

   logic [9:0]  addr;
   logic [5:0]  widx;
   logic        hit_din, hit_dout, hit_ctrl, hit_stat, hit_cnt, hit_any;
   logic        wr, rd, busy, start_req, err, ok_wr;
   logic [31:0] rdata, cnt_ext;
   logic        unused_addr;

   assign addr        = reg_req_i.addr[9:0];
   assign widx        = addr[7:2];
   assign unused_addr = ^{reg_req_i.addr[31:10], reg_req_i.addr[1:0]};

   assign hit_din  = (addr[9:8] == 2'b00) && (widx < 6'd50);
   assign hit_dout = (addr[9:8] == 2'b01) && (widx < 6'd50);
   assign hit_ctrl = (addr[9:2] == 8'h80);
   assign hit_stat = (addr[9:2] == 8'h81);
   assign hit_cnt  = (addr[9:2] == 8'h82);
   assign hit_any  = hit_din | hit_dout | hit_ctrl | hit_stat | hit_cnt;

   assign wr        = reg_req_i.valid & reg_req_i.write;
   assign rd        = reg_req_i.valid & ~reg_req_i.write;
   assign busy      = (state_q != S_IDLE);
   assign start_req = wr & hit_ctrl & reg_req_i.wstrb[0] & reg_req_i.wdata[0];

   // Any rejected request leaves every register untouched, including CTRL.IRQ_EN on a busy START.
   assign err = reg_req_i.valid & (~hit_any
              | (wr & (hit_dout | hit_cnt))
              | (wr & hit_stat & reg_req_i.wstrb[0] & reg_req_i.wdata[0])
              | (wr & hit_din & busy)
              | (start_req & busy));
   assign ok_wr = wr & ~err;

   always_comb begin
      cnt_ext = '0;
      cnt_ext[CNT_W-1:0] = cnt_q;
   end

   always_comb begin
      state_d  = state_q;
      din_d    = din_q;
      dout_d   = dout_q;
      core_d   = core_q;
      irq_en_d = irq_en_q;
      done_d   = done_q;
      cnt_d    = cnt_q;
`ifdef KECCAK_CHAIN_EN
      chain_d  = chain_q;
`endif

      if (ok_wr && hit_din) begin
         for (int b = 0; b < 4; b++) begin
            if (reg_req_i.wstrb[b]) begin
               din_d[{widx, 5'd0} + 11'(8 * b) +: 8] = reg_req_i.wdata[8 * b +: 8];
            end
         end
      end
      if (ok_wr && hit_ctrl && reg_req_i.wstrb[0]) begin
         irq_en_d = reg_req_i.wdata[1];
`ifdef KECCAK_CHAIN_EN
         chain_d  = reg_req_i.wdata[2];
`endif
      end
      if (ok_wr && hit_stat && reg_req_i.wstrb[0] && reg_req_i.wdata[1]) begin
         done_d = 1'b0;
      end

      // Completion is handled after the W1C so a coincident set wins.
      case (state_q)
         S_IDLE: begin
            if (ok_wr && start_req) begin
               state_d = S_LAUNCH;
`ifdef KECCAK_CHAIN_EN
               core_d  = chain_d ? (din_d ^ dout_q) : din_d;
`else
               core_d  = din_d;
`endif
            end
         end
         S_LAUNCH: state_d = S_WAIT;
         S_WAIT: begin
            if (core_done_i) begin
               state_d = S_IDLE;
               dout_d  = core_state_i;
               done_d  = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rdata = '0;
      if (rd && !err) begin
         if (hit_din)       rdata = din_q[{widx, 5'd0} +: 32];
         else if (hit_dout) rdata = dout_q[{widx, 5'd0} +: 32];
`ifdef KECCAK_CHAIN_EN
         else if (hit_ctrl) rdata = {29'd0, chain_q, irq_en_q, 1'b0};
`else
         else if (hit_ctrl) rdata = {29'd0, 1'b0, irq_en_q, 1'b0};
`endif
         else if (hit_stat) rdata = {30'd0, done_q, busy};
         else if (hit_cnt)  rdata = cnt_ext;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         din_q    <= '0;
         dout_q   <= '0;
         core_q   <= '0;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
`ifdef KECCAK_CHAIN_EN
         chain_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         din_q    <= din_d;
         dout_q   <= dout_d;
         core_q   <= core_d;
         irq_en_q <= irq_en_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
`ifdef KECCAK_CHAIN_EN
         chain_q  <= chain_d;
`endif
      end
   end

   assign reg_rsp_o.ready = 1'b1;
   assign reg_rsp_o.error = err;
   assign reg_rsp_o.rdata = rdata;
   assign core_state_o    = core_q;
   assign core_start_o    = (state_q == S_LAUNCH);
   assign keccak_int_o    = done_q & irq_en_q;

endmodule
